// File: rtl/damage_disp_pkg.sv
// rtl/damage_disp_pkg.sv - shared types, limits and seg_mask field layout for the damage display scheduler
package damage_disp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HUND  = 3'd2,
    TENS  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } schedState_t;

  localparam int DMG_W   = 16;
  localparam int WORK_W  = 10;
  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;
  localparam int MASK_W  = 3 * SEG_W;

  localparam int HUND_OFS = 14;
  localparam int TENS_OFS = 7;
  localparam int ONES_OFS = 0;

  localparam logic [DMG_W-1:0]  DMG_MAX  = 16'd999;
  localparam logic [WORK_W-1:0] WORK_MAX = 10'd999;

endpackage

// File: rtl/digit_seg7_enc.sv
// rtl/digit_seg7_enc.sv - BCD digit to 7-segment mask (a..g on bits 0..6) with blanking
module digit_seg7_enc
  import damage_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = '0;
    if (!blank) begin
      case (digit)
        4'd0:    seg = 7'h3F;
        4'd1:    seg = 7'h06;
        4'd2:    seg = 7'h5B;
        4'd3:    seg = 7'h4F;
        4'd4:    seg = 7'h66;
        4'd5:    seg = 7'h6D;
        4'd6:    seg = 7'h7D;
        4'd7:    seg = 7'h07;
        4'd8:    seg = 7'h7F;
        4'd9:    seg = 7'h6F;
        default: seg = 7'h00;
      endcase
    end
  end

endmodule

// File: rtl/damage_display_sched.sv
// rtl/damage_display_sched.sv - per-frame damage to 7-segment conversion by repeated subtraction
module damage_display_sched
  import damage_disp_pkg::*;
#(
  parameter int NUM_PLAYERS = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic [NUM_PLAYERS*DMG_W-1:0]  damage,
  output logic [NUM_PLAYERS*MASK_W-1:0] seg_mask,
  output logic                          busy,
  output logic                          frame_done
);

  localparam logic [1:0] LAST_P = 2'(NUM_PLAYERS - 1);

  schedState_t                   state;
  logic [1:0]                    playerIdx;
  logic [NUM_PLAYERS*DMG_W-1:0]  snapshot;
  logic [NUM_PLAYERS*MASK_W-1:0] shadow;
  logic [NUM_PLAYERS*MASK_W-1:0] shadowNext;
  logic [WORK_W-1:0]             work;
  logic [DIGIT_W-1:0]            hundCnt;
  logic [DIGIT_W-1:0]            tensCnt;

  logic [DMG_W-1:0]  curDmg;
  logic [WORK_W-1:0] clampedDmg;
  logic [SEG_W-1:0]  hundSeg, tensSeg, onesSeg;
  logic [MASK_W-1:0] newEntry;

  assign curDmg     = snapshot[int'(playerIdx)*DMG_W +: DMG_W];
  assign clampedDmg = (curDmg > DMG_MAX) ? WORK_MAX : curDmg[WORK_W-1:0];

  digit_seg7_enc hundEnc (
    .digit(hundCnt),
    .blank(hundCnt == '0),
    .seg  (hundSeg)
  );

  digit_seg7_enc tensEnc (
    .digit(tensCnt),
    .blank((hundCnt == '0) && (tensCnt == '0)),
    .seg  (tensSeg)
  );

  // work is below 10 by the time WRITE uses it, so its low nibble is the ones digit
  digit_seg7_enc onesEnc (
    .digit(work[DIGIT_W-1:0]),
    .blank(1'b0),
    .seg  (onesSeg)
  );

  always_comb begin
    newEntry = '0;
    newEntry[HUND_OFS +: SEG_W] = hundSeg;
    newEntry[TENS_OFS +: SEG_W] = tensSeg;
    newEntry[ONES_OFS +: SEG_W] = onesSeg;
  end

  // The last player's entry must reach seg_mask on the same edge it lands in shadow
  always_comb begin
    shadowNext = shadow;
    shadowNext[int'(playerIdx)*MASK_W +: MASK_W] = newEntry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      playerIdx  <= '0;
      snapshot   <= '0;
      shadow     <= '0;
      seg_mask   <= '0;
      work       <= '0;
      hundCnt    <= '0;
      tensCnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            snapshot  <= damage;
            playerIdx <= '0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          work    <= clampedDmg;
          hundCnt <= '0;
          tensCnt <= '0;
          state   <= HUND;
        end
        HUND: begin
          if (work >= 10'd100) begin
            work    <= work - 10'd100;
            hundCnt <= hundCnt + 4'd1;
          end else begin
            state <= TENS;
          end
        end
        TENS: begin
          if (work >= 10'd10) begin
            work    <= work - 10'd10;
            tensCnt <= tensCnt + 4'd1;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: begin
          shadow <= shadowNext;
          if (playerIdx == LAST_P) begin
            seg_mask   <= shadowNext;
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            playerIdx <= playerIdx + 2'd1;
            state     <= LOAD;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_damage_display_sched.sv
// tb/tb_damage_display_sched.sv - directed vector bench for damage_display_sched
module tb_damage_display_sched;

  logic        clock;
  logic        reset;
  logic        frame_start;
  logic [31:0] damage;
  logic [41:0] seg_mask;
  logic        busy;
  logic        frame_done;

  int testsRun = 0;
  int testsFailed = 0;

  damage_display_sched #(.NUM_PLAYERS(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_start(frame_start),
    .damage     (damage),
    .seg_mask   (seg_mask),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [20:0] m0;
    logic [20:0] m1;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [20:0] mk(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
    return {h, t, o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts a pass in the current cycle (cycle 0) and follows it to frame_done
  task automatic runFrame(input string name, input logic [15:0] d0, input logic [15:0] d1,
                          input logic [20:0] m0, input logic [20:0] m1, input int lat);
    int  cnt;
    logic busyBad;
    damage      = {d1, d0};
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    cnt     = 1;
    busyBad = 1'b0;
    while (frame_done !== 1'b1 && cnt < 200) begin
      if (busy !== 1'b1) busyBad = 1'b1;
      tick();
      cnt++;
    end
    if (busy !== 1'b1) busyBad = 1'b1;
    check({name, " latency"}, 64'(cnt), 64'(lat));
    check({name, " busy during pass"}, 64'(busyBad), 64'd0);
    check({name, " mask p0"}, 64'(seg_mask[20:0]), 64'(m0));
    check({name, " mask p1"}, 64'(seg_mask[41:21]), 64'(m1));
    tick();
    check({name, " idle after done"}, 64'({busy, frame_done}), 64'd0);
  endtask

  initial begin
    int  doneCount;
    logic stableBad;
    logic [41:0] held;

    vecs[0] = '{16'd0,     16'd0,    mk(7'h00, 7'h00, 7'h3F), mk(7'h00, 7'h00, 7'h3F), 9};
    vecs[1] = '{16'd123,   16'd105,  mk(7'h06, 7'h5B, 7'h4F), mk(7'h06, 7'h3F, 7'h6D), 13};
    vecs[2] = '{16'd1050,  16'd7,    mk(7'h6F, 7'h6F, 7'h6F), mk(7'h00, 7'h00, 7'h07), 27};
    vecs[3] = '{16'd999,   16'd1000, mk(7'h6F, 7'h6F, 7'h6F), mk(7'h6F, 7'h6F, 7'h6F), 45};
    vecs[4] = '{16'd10,    16'd100,  mk(7'h00, 7'h06, 7'h3F), mk(7'h06, 7'h3F, 7'h3F), 11};
    vecs[5] = '{16'd65535, 16'd58,   mk(7'h6F, 7'h6F, 7'h6F), mk(7'h00, 7'h6D, 7'h7F), 32};
    vecs[6] = '{16'd9,     16'd90,   mk(7'h00, 7'h00, 7'h6F), mk(7'h00, 7'h6F, 7'h3F), 18};
    vecs[7] = '{16'd456,   16'd780,  mk(7'h66, 7'h6D, 7'h7D), mk(7'h07, 7'h7F, 7'h3F), 33};

    reset       = 1'b1;
    frame_start = 1'b0;
    damage      = '0;
    tick();
    tick();
    check("reset seg_mask", 64'(seg_mask), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      runFrame($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].m0, vecs[i].m1, vecs[i].lat);
    end

    // Retrigger and damage changes mid-pass must not disturb the snapshot
    damage      = {16'd105, 16'd123};
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    doneCount   = 0;
    for (int c = 1; c < 60; c++) begin
      if (c == 3) begin
        frame_start = 1'b1;
        damage      = {16'd999, 16'd999};
      end else if (c == 4) begin
        frame_start = 1'b0;
        damage      = {16'd42, 16'd7};
      end
      if (frame_done === 1'b1) doneCount++;
      tick();
    end
    check("retrigger done count", 64'(doneCount), 64'd1);
    check("retrigger mask p0", 64'(seg_mask[20:0]), 64'(mk(7'h06, 7'h5B, 7'h4F)));
    check("retrigger mask p1", 64'(seg_mask[41:21]), 64'(mk(7'h06, 7'h3F, 7'h6D)));

    // Inputs toggling with no frame_start must leave seg_mask alone
    held      = seg_mask;
    stableBad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      damage = $urandom();
      tick();
      if (seg_mask !== held || busy !== 1'b0 || frame_done !== 1'b0) stableBad = 1'b1;
    end
    check("stable between frames", 64'(stableBad), 64'd0);

    // Reset during player 1's HUND phase (player 1 = 500, cycles 6..11)
    damage      = {16'd500, 16'd0};
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort seg_mask", 64'(seg_mask), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort frame_done", 64'(frame_done), 64'd0);
    doneCount = 0;
    for (int c = 0; c < 40; c++) begin
      if (frame_done !== 1'b0 || busy !== 1'b0 || seg_mask !== '0) doneCount++;
      tick();
    end
    check("abort stays quiet", 64'(doneCount), 64'd0);
    runFrame("after abort", 16'd123, 16'd105, mk(7'h06, 7'h5B, 7'h4F), mk(7'h06, 7'h3F, 7'h6D), 13);

    // Reset wins over a simultaneous frame_start
    damage      = {16'd1, 16'd1};
    reset       = 1'b1;
    frame_start = 1'b1;
    tick();
    reset       = 1'b0;
    frame_start = 1'b0;
    check("reset priority busy", 64'(busy), 64'd0);
    check("reset priority mask", 64'(seg_mask), 64'd0);
    tick();
    check("reset priority no pass", 64'({busy, frame_done}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
